// File: rtl/dcache_flush_ctrl.sv
// rtl/dcache_flush_ctrl.sv - halt-time data cache flush sequencer
// Drains the write buffer, writes back dirty lines, invalidates all lines, then stores the hit count.
module dcache_flush_ctrl #(
  parameter int          SETS        = 8,
  parameter int          WAYS        = 2,
  parameter int          WORDS       = 2,
  parameter int          TAG_W       = 26,
  parameter logic [31:0] HITCNT_ADDR = 32'h3100,
  localparam int         IDX_W       = $clog2(SETS),
  localparam int         WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int         WRD_W       = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             halt,
  input  logic             wempty,
  input  logic             lvalid,
  input  logic             ldirty,
  input  logic [TAG_W-1:0] ltag,
  input  logic [31:0]      ldata,
  input  logic [31:0]      hitcnt,
  input  logic             dwait,
  output logic [IDX_W-1:0] lidx,
  output logic [WAY_W-1:0] lway,
  output logic [WRD_W-1:0] lword,
  output logic             linval,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      ddata,
  output logic             busy,
  output logic             flushed
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, CHECK, WRITE, INVAL, HITCNT, DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [WRD_W-1:0] word_q, word_d;
  logic             adv;
  logic             last_way, last_set, last_word;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      way_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      way_q   <= way_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    way_d     = way_q;
    word_d    = word_q;
    adv       = 1'b0;
    linval    = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    ddata     = '0;
    last_way  = (way_q == WAY_W'(WAYS - 1));
    last_set  = (idx_q == IDX_W'(SETS - 1));
    last_word = (word_q == WRD_W'(WORDS - 1));

    unique case (state_q)
      IDLE: if (halt) state_d = DRAIN;
      DRAIN: begin
        if (wempty) begin
          state_d = CHECK;
          idx_d   = '0;
          way_d   = '0;
          word_d  = '0;
        end
      end
      CHECK: begin
        if (lvalid && ldirty) begin
          state_d = WRITE;
          word_d  = '0;
        end else begin
          linval = lvalid;
          adv    = 1'b1;
        end
      end
      WRITE: begin
        dWEN  = 1'b1;
        daddr = {ltag, idx_q, word_q, 2'b00};
        ddata = ldata;
        if (!dwait) begin
          if (last_word) state_d = INVAL;
          else           word_d  = word_q + WRD_W'(1);
        end
      end
      INVAL: begin
        linval  = 1'b1;
        word_d  = '0;
        state_d = CHECK;
        adv     = 1'b1;
      end
      HITCNT: begin
        dWEN  = 1'b1;
        daddr = HITCNT_ADDR;
        ddata = hitcnt;
        if (!dwait) state_d = DONE;
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Way is the fast index; the final line exits to the hit-count store.
    if (adv) begin
      if (last_way && last_set) begin
        state_d = HITCNT;
      end else if (last_way) begin
        way_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        way_d = way_q + WAY_W'(1);
      end
    end
  end

  assign lidx    = idx_q;
  assign lway    = way_q;
  assign lword   = word_q;
  assign busy    = (state_q != IDLE);
  assign flushed = (state_q == DONE);

endmodule
